mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared-memory, PC, IR, register-file and ALU select/enable lines, and stalls on a memory ready handshake. Supported opcodes: R-type, lw, sw, beq, j, jal, addi, ori, lui.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; held by the IR from decode through writeback
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC (already PC+4)
- RegDst  out  2  write reg: 00 rt, 01 rd, 10 $31
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
- ZeroExt  out  1  immediate extender: 1 = zero-extend (ori), 0 = sign-extend
- ALUOp  out  3  000 add, 001 sub, 010 use funct, 011 lui, 100 or
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  unsupported opcode seen in DECODE
- state  out  4  current state encoding, for debug/verification

## Operation
- States, with fixed encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JAL 12.
- Outputs are decoded combinationally from the state. IEXEC and illegal_op also depend on opcode. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
  - Next state by opcode: 000000→EXEC; 100011/101011→MEMADR; 000100→BRANCH; 000010→JUMP; 000011→JAL; 001000/001101/001111→IEXEC.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=000.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB:
  - Outputs: RegWrite=1, RegDst=00, MemtoReg=01.
  - Next state FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Waits for mem_ready, then goes to FETCH.
  - MemWrite stays high for every wait cycle.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=010.
  - Next state ALUWB.
- ALUWB:
  - Outputs: RegWrite=1, RegDst=01, MemtoReg=00.
  - Next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01.
  - Next state FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - Next state FETCH.
- JAL:
  - Outputs: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10.
  - Next state FETCH. Register write and PC write happen on the same edge; the register file captures the old PC+4.
- IEXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - ALUOp is 000 for addi, 100 for ori (with ZeroExt=1), 011 for lui.
  - Next state IWB.
- IWB:
  - Outputs: RegWrite=1, RegDst=00, MemtoReg=00.
  - Next state FETCH.

## Timing
- Reset:
  - While reset=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0.
  - At the first edge with reset=1, state becomes FETCH (0).
  - Reset values of all other outputs are the FETCH values: MemRead=1, ALUSrcB=01, everything else 0.
- Reset mid-instruction:
  - Aborts at the next edge with no further register or memory write.
  - This includes MEMWR with mem_ready=1 on the same cycle as reset.
- Cycle counts with mem_ready tied to 1:
  - lw: 5
  - sw, R-type, addi, ori, lui: 4
  - beq, j, jal: 3
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs stay constant during the wait.
- mem_ready is ignored in every other state.
- The controller needs opcode to be stable only from DECODE to the end of the instruction. IRWrite is never asserted outside FETCH.

## Test plan
- Reset, then lw (opcode 100011) with mem_ready=1:
  - state sequence 0,1,2,3,4,0
  - RegWrite=1 only in state 4, with MemtoReg=01
  - IRWrite and PCWrite pulse once, in the cycle of state 0.
- sw (opcode 101011) with mem_ready=0 for 3 cycles in MEMWR:
  - state stays 5 for 4 cycles with MemWrite=1 throughout
  - then goes to 0
  - RegWrite never asserts.
- beq (000100), j (000010), jal (000011) back to back:
  - each takes 3 cycles
  - jal state 12 drives RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10.
- addi, ori, lui in sequence:
  - IEXEC ALUOp is 000, 100 (ZeroExt=1), 011 respectively
  - IWB drives RegDst=00 for each.
- Opcode 111111:
  - illegal_op=1 for one cycle in state 1, then state 0
  - no write enable asserts.
- reset=1 asserted in state 5 with mem_ready=1:
  - MemWrite=0 that cycle
  - state=0 after the edge.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Multi-cycle MIPS sequencer. This is a Moore FSM that steps each instruction
// through fetch, decode, execute, memory and writeback. It stalls in FETCH,
// MEMRD and MEMWR until mem_ready is high.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       IR[31:26], stable from DECODE through writeback
//   mem_ready         memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg[1:0], RegDst[1:0], RegWrite, ALUSrcA, ALUSrcB[1:0],
//   ZeroExt, ALUOp[2:0], PCSource[1:0]   datapath control lines
//   illegal_op        unsupported opcode seen in DECODE
//   state[3:0]        current state encoding (debug)
//
// state  | meaning
// 0      | FETCH   read instruction, PC <= PC+4 on mem_ready
// 1      | DECODE  dispatch on opcode, branch target into ALUOut
// 2      | MEMADR  lw/sw effective address
// 3      | MEMRD   load data read, wait on mem_ready
// 4      | MEMWB   load writeback (rt <= MDR)
// 5      | MEMWR   store, wait on mem_ready
// 6      | EXEC    R-type ALU operation
// 7      | ALUWB   R-type writeback (rd <= ALUOut)
// 8      | BRANCH  beq compare and conditional PC load
// 9      | JUMP    j
// 10     | IEXEC   addi/ori/lui ALU operation
// 11     | IWB     immediate writeback (rt <= ALUOut)
// 12     | JAL     $31 <= PC+4, PC <= jump target

module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  state_t cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      unique case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          unique case (opcode)
            OP_RTYPE:                 cur <= S_EXEC;
            OP_LW, OP_SW:             cur <= S_MEMADR;
            OP_BEQ:                   cur <= S_BRANCH;
            OP_J:                     cur <= S_JUMP;
            OP_JAL:                   cur <= S_JAL;
            OP_ADDI, OP_ORI, OP_LUI:  cur <= S_IEXEC;
            default:                  cur <= S_FETCH;
          endcase
        end
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_EXEC:   cur <= S_ALUWB;
        S_IEXEC:  cur <= S_IWB;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  assign state = cur;

  // Outputs follow the state combinationally. While reset is high they show
  // the FETCH values with every write enable held low, so an access that is
  // in flight when reset arrives is dropped.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    if (reset) begin
      MemRead = 1'b1;
      ALUSrcB = 2'b01;
    end else begin
      unique case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          unique case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL,
            OP_ADDI, OP_ORI, OP_LUI: illegal_op = 1'b0;
            default:                 illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (opcode == OP_ORI) begin
            ALUOp   = 3'b100;
            ZeroExt = 1'b1;
          end else if (opcode == OP_LUI) begin
            ALUOp = 3'b011;
          end
        end
        S_IWB: begin
          RegWrite = 1'b1;
        end
        S_JAL: begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
